// File: rtl/axi_lite_spi_master.sv
// AXI4-Lite slave wrapping a single-lane SPI master; one write and one read outstanding at a time.
// Responses appear the cycle after the handshake and hold until bready/rready; writes while busy get SLVERR.
module axi_lite_spi_master #(
  parameter int NUM_CS   = 6,
  parameter int MAX_BITS = 32,
  parameter int DIV_W    = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [3:0]        s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [3:0]        s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] spi_cs_b,
  output logic              spi_data_o,
  output logic              spi_data_t,
  input  logic              spi_data_i,
  output logic              spi_busy,
  output logic              irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Bit k of the frame lives at TXDATA[k] (lsb first) or TXDATA[len-1-k] (msb first).
  function automatic logic [4:0] bit_pos(input logic lsb, input logic [4:0] len_m1, input logic [4:0] k);
    return lsb ? k : (len_m1 - k);
  endfunction

  state_t             state_q, state_d;
  logic               awready_q, awready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, dt_q, dt_d;
  logic [4:0]         len_q, len_d;
  logic [NUM_CS-1:0]  cs_q, cs_d;
  logic [DIV_W-1:0]   div_q, div_d, cnt_q, cnt_d;
  logic [31:0]        tx_q, tx_d, rxd_q, rxd_d, rx_sh_q, rx_sh_d;
  logic               done_q, done_d;
  logic               spi_clk_q, spi_clk_d, data_o_q, data_o_d;
  logic [6:0]         edge_q, edge_d;

  logic               busy, wr_fire, rd_fire, start_go, done_set, done_clr;
  logic [31:0]        ctrl_rd, status_rd, wr_old, wr_merged, rd_mux;
  logic [4:0]         len_wr, len_clamped;
  logic [5:0]         len_p1, out_idx;
  logic [6:0]         last_edge;
  logic               unused_ok;

  assign busy      = (state_q == SHIFT);
  assign status_rd = {30'b0, done_q, busy};
  assign wr_fire   = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire   = arready_q && s_axi_arvalid;
  assign len_p1    = {1'b0, len_q} + 6'd1;
  assign last_edge = {len_p1, 1'b0} - 7'd1;
  assign out_idx   = 6'((edge_q + 7'd1) >> 1);

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[1]           = cpol_q;
    ctrl_rd[2]           = cpha_q;
    ctrl_rd[3]           = lsb_q;
    ctrl_rd[4]           = dt_q;
    ctrl_rd[12:8]        = len_q;
    ctrl_rd[16 +: NUM_CS] = cs_q;
  end

  always_comb begin
    case (s_axi_awaddr[3:2])
      2'd0:    wr_old = ctrl_rd;
      2'd1:    wr_old = 32'(div_q);
      2'd2:    wr_old = tx_q;
      default: wr_old = status_rd;
    endcase
    wr_merged   = merge_bytes(wr_old, s_axi_wdata, s_axi_wstrb);
    len_wr      = wr_merged[12:8];
    len_clamped = (32'(len_wr) >= MAX_BITS) ? 5'(MAX_BITS - 1) : len_wr;
  end

  always_comb begin
    case (s_axi_araddr[3:2])
      2'd0:    rd_mux = ctrl_rd;
      2'd1:    rd_mux = 32'(div_q);
      2'd2:    rd_mux = rxd_q;
      default: rd_mux = status_rd;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    awready_d = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = s_axi_arvalid && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    dt_d      = dt_q;
    len_d     = len_q;
    cs_d      = cs_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rxd_d     = rxd_q;
    rx_sh_d   = rx_sh_q;
    spi_clk_d = spi_clk_q;
    data_o_d  = data_o_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    start_go  = 1'b0;
    done_set  = 1'b0;
    done_clr  = 1'b0;

    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      if (s_axi_awaddr[3:2] == 2'd3) begin
        done_clr = s_axi_wstrb[0] & s_axi_wdata[1];
      end else if (busy) begin
        bresp_d = RESP_SLVERR;
      end else begin
        case (s_axi_awaddr[3:2])
          2'd0: begin
            start_go = s_axi_wstrb[0] & s_axi_wdata[0];
            cpol_d   = wr_merged[1];
            cpha_d   = wr_merged[2];
            lsb_d    = wr_merged[3];
            dt_d     = wr_merged[4];
            len_d    = len_clamped;
            cs_d     = wr_merged[16 +: NUM_CS];
          end
          2'd1:    div_d = wr_merged[DIV_W-1:0];
          default: tx_d  = wr_merged;
        endcase
      end
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end

    // Start uses the freshly written CTRL so cpol/cpha/len take effect on the same write.
    case (state_q)
      IDLE: begin
        spi_clk_d = cpol_d;
        cnt_d     = '0;
        edge_d    = '0;
        if (start_go) begin
          state_d  = SHIFT;
          rx_sh_d  = '0;
          data_o_d = cpha_d ? 1'b0 : tx_q[bit_pos(lsb_d, len_d, 5'd0)];
        end
      end
      SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d     = '0;
          spi_clk_d = ~spi_clk_q;
          edge_d    = edge_q + 7'd1;
          if (edge_q[0] == cpha_q) begin
            rx_sh_d[bit_pos(lsb_q, len_q, edge_q[5:1])] = spi_data_i;
          end else if (out_idx < len_p1) begin
            data_o_d = tx_q[bit_pos(lsb_q, len_q, out_idx[4:0])];
          end
          if (edge_q == last_edge) begin
            state_d  = IDLE;
            rxd_d    = rx_sh_d;
            done_set = 1'b1;
            data_o_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
    endcase

    done_d = (done_q & ~done_clr) | done_set;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      dt_q      <= 1'b1;
      len_q     <= '0;
      cs_q      <= '1;
      div_q     <= '0;
      tx_q      <= '0;
      rxd_q     <= '0;
      rx_sh_q   <= '0;
      done_q    <= 1'b0;
      spi_clk_q <= 1'b0;
      data_o_q  <= 1'b0;
      cnt_q     <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      dt_q      <= dt_d;
      len_q     <= len_d;
      cs_q      <= cs_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rxd_q     <= rxd_d;
      rx_sh_q   <= rx_sh_d;
      done_q    <= done_d;
      spi_clk_q <= spi_clk_d;
      data_o_q  <= data_o_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign spi_clk       = spi_clk_q;
  assign spi_cs_b      = cs_q;
  assign spi_data_o    = data_o_q;
  assign spi_data_t    = dt_q;
  assign spi_busy      = busy;
  assign irq           = done_q;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0], wr_merged};

endmodule

// File: tb/tb_axi_lite_spi_master.sv
// Scoreboard bench: B/R responses are queued at issue time and checked by monitors; SPI pins checked inline.
module tb_axi_lite_spi_master;

  localparam logic [3:0] A_CTRL = 4'h0, A_DIV = 4'h4, A_DATA = 4'h8, A_STAT = 4'hC;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic        spi_clk, spi_data_o, spi_data_t, spi_data_i, spi_busy, irq;
  logic [5:0]  spi_cs_b;

  int checks = 0;
  int failures = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  string       rn[$];

  always #5 aclk = ~aclk;
  assign spi_data_i = spi_data_o;

  axi_lite_spi_master dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .spi_clk(spi_clk), .spi_cs_b(spi_cs_b), .spi_data_o(spi_data_o), .spi_data_t(spi_data_t),
    .spi_data_i(spi_data_i), .spi_busy(spi_busy), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Response monitors
  always @(negedge aclk) begin
    if (!areset && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) timeout("b_unexpected");
      else check("bresp", 32'(s_axi_bresp), 32'(bq.pop_front()));
    end
    if (!areset && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) timeout("r_unexpected");
      else begin
        check({"rdata_", rn.pop_front()}, s_axi_rdata, rq.pop_front());
        check("rresp", 32'(s_axi_rresp), 32'(OKAY));
      end
    end
  end

  task automatic wr_start(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] exp);
    bq.push_back(exp);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
  endtask

  task automatic wr_finish();
    int n = 0;
    @(negedge aclk);
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge aclk); n++; end
    if (!(s_axi_awready && s_axi_wready)) timeout("awready");
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] exp);
    wr_start(a, d, s, exp);
    wr_finish();
  endtask

  task automatic rd_start(input logic [3:0] a, input logic [31:0] exp, input string name);
    rq.push_back(exp); rn.push_back(name);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
  endtask

  task automatic rd_finish();
    int n = 0;
    @(negedge aclk);
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    if (!s_axi_arready) timeout("arready");
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_start(a, exp, name);
    rd_finish();
  endtask

  // Observes one transfer: busy length, rising spi_clk edges and the bit present at each leading edge.
  task automatic run_xfer(input logic cpol, output int busy_cyc, output int rises, output logic [31:0] seq);
    logic prev;
    int guard = 0;
    busy_cyc = 0; rises = 0; seq = '0; prev = spi_clk;
    while (guard < 2000) begin
      @(negedge aclk);
      guard++;
      if (!spi_busy) break;
      busy_cyc++;
      if (!prev && spi_clk) rises++;
      if (prev == cpol && spi_clk != cpol) seq = {seq[30:0], spi_data_o};
      prev = spi_clk;
    end
    if (guard >= 2000) timeout("xfer_busy");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (spi_busy && n < 2000) begin @(negedge aclk); n++; end
    if (spi_busy) timeout("wait_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, rc;
    logic [31:0] sq;
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;

    repeat (3) @(negedge aclk);
    check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'b0000);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_spi", {spi_clk, spi_data_o, spi_data_t, spi_busy, irq}, 5'b00100);
    check("rst_cs", 32'(spi_cs_b), 32'h3F);
    @(posedge aclk); #1 areset = 1'b0;

    axi_read(A_CTRL, 32'h003F0010, "ctrl_rst");
    axi_read(A_DIV,  32'h0, "div_rst");
    axi_read(A_DATA, 32'h0, "rx_rst");
    axi_read(A_STAT, 32'h0, "status_rst");

    // Byte strobes: only enabled lanes change; unstrobed start bit does nothing
    axi_write(A_CTRL, 32'hFF120000, 4'b0100, OKAY);
    axi_read(A_CTRL, 32'h00120010, "ctrl_strb_cs");
    check("cs_follow", 32'(spi_cs_b), 32'h12);
    axi_write(A_CTRL, 32'h00000F01, 4'b0010, OKAY);
    axi_read(A_CTRL, 32'h00120F10, "ctrl_strb_len");
    axi_read(A_STAT, 32'h0, "status_no_start");

    // Mode 0, msb first, 8 bits, DIV=1, loopback
    axi_write(A_DIV, 32'h1, 4'hF, OKAY);
    axi_write(A_DATA, 32'hA5, 4'hF, OKAY);
    check("dt_follow", spi_data_t, 1'b1);
    axi_write(A_CTRL, 32'h003E0701, 4'hF, OKAY);
    check("dt_low", spi_data_t, 1'b0);
    run_xfer(1'b0, bc, rc, sq);
    check("m0_busy_cycles", bc, 32);
    check("m0_rises", rc, 8);
    check("m0_bits", sq, 32'hA5);
    check("m0_irq", irq, 1'b1);
    check("m0_data_o_idle", spi_data_o, 1'b0);
    axi_read(A_DATA, 32'hA5, "m0_rx");
    axi_read(A_STAT, 32'h2, "m0_status");

    // Mode 3, lsb first, 12 bits
    axi_write(A_STAT, 32'h2, 4'hF, OKAY);
    axi_read(A_STAT, 32'h0, "done_cleared");
    check("irq_cleared", irq, 1'b0);
    axi_write(A_DATA, 32'h5C3, 4'hF, OKAY);
    axi_write(A_CTRL, 32'h003E0B0F, 4'hF, OKAY);
    check("m3_clk_idle_start", spi_clk, 1'b1);
    run_xfer(1'b1, bc, rc, sq);
    check("m3_busy_cycles", bc, 48);
    check("m3_bits", sq, 32'hC3A);
    check("m3_clk_idle_end", spi_clk, 1'b1);
    axi_read(A_DATA, 32'h5C3, "m3_rx");
    axi_read(A_CTRL, 32'h003E0B0E, "m3_ctrl");

    // Writes during a transfer are rejected; RX keeps the previous result until the end
    axi_write(A_STAT, 32'h2, 4'hF, OKAY);
    axi_write(A_DATA, 32'h3C, 4'hF, OKAY);
    axi_write(A_CTRL, 32'h003E0701, 4'hF, OKAY);
    axi_write(A_DATA, 32'hFF, 4'hF, SLVERR);
    axi_write(A_DIV, 32'h5, 4'hF, SLVERR);
    axi_write(A_CTRL, 32'h00000000, 4'hF, SLVERR);
    axi_read(A_DATA, 32'h5C3, "rx_during_busy");
    axi_read(A_STAT, 32'h1, "status_busy");
    wait_idle();
    axi_read(A_DATA, 32'h3C, "rx_after_reject");
    axi_read(A_DIV, 32'h1, "div_after_reject");
    axi_read(A_CTRL, 32'h003E0700, "ctrl_after_reject");

    // W1C landing on the completion cycle: set wins
    axi_write(A_STAT, 32'h2, 4'hF, OKAY);
    axi_read(A_STAT, 32'h0, "done_cleared2");
    axi_write(A_CTRL, 32'h003E0701, 4'hF, OKAY);
    repeat (30) @(posedge aclk);
    #1;
    axi_write(A_STAT, 32'h2, 4'hF, OKAY);
    axi_read(A_STAT, 32'h2, "done_set_wins");

    // Reset mid-transfer with cpol=1
    axi_write(A_CTRL, 32'h003E0703, 4'hF, OKAY);
    repeat (12) @(posedge aclk);
    #1;
    check("pre_rst_clk", spi_clk, 1'b1);
    check("pre_rst_busy", spi_busy, 1'b1);
    areset = 1'b1;
    #2;
    check("midrst_clk", spi_clk, 1'b0);
    check("midrst_cs", 32'(spi_cs_b), 32'h3F);
    check("midrst_busy_irq", {spi_busy, irq}, 2'b00);
    @(posedge aclk); #1 areset = 1'b0;
    axi_read(A_CTRL, 32'h003F0010, "ctrl_after_rst");
    axi_read(A_DIV, 32'h0, "div_after_rst");
    axi_write(A_DIV, 32'h2, 4'hF, OKAY);
    axi_write(A_DATA, 32'h96, 4'hF, OKAY);
    axi_write(A_CTRL, 32'h003E0705, 4'hF, OKAY);
    run_xfer(1'b0, bc, rc, sq);
    check("m1_busy_cycles", bc, 48);
    check("m1_rises", rc, 8);
    check("m1_bits", sq, 32'h96);
    axi_read(A_DATA, 32'h96, "m1_rx");

    // Backpressure on B and R
    s_axi_bready = 1'b0;
    axi_write(A_DIV, 32'h3, 4'hF, OKAY);
    wr_start(A_DIV, 32'h7, 4'hF, OKAY);
    repeat (5) begin
      @(negedge aclk);
      check("b_hold_bvalid", s_axi_bvalid, 1'b1);
      check("b_hold_awready", s_axi_awready, 1'b0);
    end
    @(posedge aclk); #1 s_axi_bready = 1'b1;
    wr_finish();
    s_axi_rready = 1'b0;
    axi_read(A_DIV, 32'h7, "div_hold");
    rd_start(A_CTRL, 32'h003E0704, "ctrl_hold");
    repeat (5) begin
      @(negedge aclk);
      check("r_hold_rvalid", s_axi_rvalid, 1'b1);
      check("r_hold_arready", s_axi_arready, 1'b0);
      check("r_hold_rdata", s_axi_rdata, 32'h7);
    end
    @(posedge aclk); #1 s_axi_rready = 1'b1;
    rd_finish();

    repeat (10) @(negedge aclk);
    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
